wb_ifetch: RTL and testbench

WB_IFETCH -- requirements
Module: wb_ifetch

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifetch_fifo.sv | 91 +++++++++
 rtl/wb_ifetch.sv | 172 +++++++++++++++++
 tb/tb_wb_ifetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Package    : ifetch_pkg
// Description: Shared types and constants for the wb_ifetch instruction
//              prefetcher: fetch FSM state encoding, Wishbone byte-select
//              constant and bus timeout length.
// Revision   : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    FLUSH = 2'd2,
    ERR   = 2'd3
  } ifetch_state_e;

  localparam logic [1:0] WB_SEL_ALL     = 2'b11;
  localparam int         TIMEOUT_CYCLES = 16;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module     : ifetch_fifo
// Description: Prefetch FIFO holding {pc, insn} entries. Registered storage
//              and pointers; head_o reads the oldest entry directly from the
//              storage registers. clear_i empties the FIFO and wins over
//              push/pop. Push when full and pop when empty are ignored.
// Ports      : clk_i, rst_i (async, active-high)
//              push_i/data_i  - write one entry
//              pop_i          - drop the head entry
//              clear_i        - discard all entries
//              head_o         - oldest entry
//              count_o        - number of stored entries (0..DEPTH)
//              full_o/empty_o - occupancy flags
// Revision   : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]     DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : ifetch_fifo
`default_nettype wire

// File: rtl/wb_ifetch.sv
`default_nettype none
// ============================================================================
// Module     : wb_ifetch
// Description: Wishbone instruction prefetcher. Reads sequential words into a
//              DEPTH-entry FIFO and presents the head as insn_o/pc_o. A flush
//              discards all prefetched words and restarts at branch_target_i.
// Ports      : clk_i, rst_i (async, active-high)
//              wb_*            - Wishbone read master (cyc == stb)
//              flush_i         - discard FIFO, restart at branch_target_i
//              insn_o/pc_o     - head instruction and its address
//              valid_o/ready_i - consumer handshake
//              err_o           - bus timeout flag
// Config     : define WB_IFETCH_TIMEOUT_EN to enable the bus timeout: after
//              TIMEOUT_CYCLES bus cycles with no ack the fetcher parks in ERR
//              with err_o high until flush_i. Without it err_o is tied 0.
// Revision   : 1.0 - initial release
// ============================================================================
module wb_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_tga_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] insn_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        err_o
);

  import ifetch_pkg::*;

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ifetch_state_e    state_q, state_d;
  logic [31:0]      fa_q, fa_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_after;
  logic [63:0]      head;
  logic             full, empty;
  logic             bus_req, push, pop;
  logic             unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^branch_target_i[1:0];

  // Constant Wishbone outputs of a read-only master.
  assign wb_dat_o = 32'h0;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = WB_SEL_ALL;
  assign wb_tga_o = 1'b0;
  assign wb_adr_o = fa_q;
  assign wb_cyc_o = bus_req;
  assign wb_stb_o = bus_req;

  assign valid_o  = ~empty;
  assign insn_o   = head[31:0];
  assign pc_o     = head[63:32];

  // Occupancy after this cycle's push/pop; decides whether BUS continues.
  assign cnt_after = count + CNT_W'(push) - CNT_W'(pop);

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush_i),
    .data_i  ({fa_q, wb_dat_i}),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef WB_IFETCH_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts consecutive unacknowledged BUS cycles; cleared anywhere else.
  always_comb begin
    tmo_d = '0;
    if (state_q == BUS && !wb_ack_i && !flush_i) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // State register and fetch address register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fa_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count < DEPTH_C) state_d = BUS;
      end
      BUS: begin
        if (wb_ack_i) begin
          state_d = (cnt_after < DEPTH_C) ? BUS : IDLE;
        end
`ifdef WB_IFETCH_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end
`endif
      end
      FLUSH:   state_d = BUS;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = FLUSH;
  end

  // Fetch address: reload on flush, advance by one word per accepted push.
  always_comb begin
    fa_d = fa_q;
    if (flush_i) begin
      fa_d = {branch_target_i[31:2], 2'b00};
    end else if (push) begin
      fa_d = fa_q + 32'd4;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus_req = (state_q == BUS);
    push    = bus_req & wb_ack_i & ~flush_i & ~full;
    pop     = valid_o & ready_i & ~flush_i;
  end

`ifdef WB_IFETCH_TIMEOUT_EN
  assign err_o = (state_q == ERR);
`else
  assign err_o = 1'b0;
`endif

endmodule : wb_ifetch
`default_nettype wire

// File: tb/tb_wb_ifetch.sv
`default_nettype none
// ============================================================================
// Module     : tb_wb_ifetch
// Description: Self-checking bench for wb_ifetch. A combinational-ack ROM
//              slave feeds the fetcher; a queue-based reference model tracks
//              the words the consumer should see and the next fetch address.
//              Directed scenarios cover reset, streaming, FIFO fill, flush,
//              address wrap, reset mid-cycle and the bus timeout; a random
//              phase mixes ack, ready and flush.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_wb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_tga_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;
  logic        ack_en;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state.
  logic [63:0] mq[$];
  logic [31:0] exp_fa;
  bit          low_prev;
  bit          tmo_test;
  int          n_ack;

  wb_ifetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .wb_adr_o        (wb_adr_o),
    .wb_dat_i        (wb_dat_i),
    .wb_dat_o        (wb_dat_o),
    .wb_we_o         (wb_we_o),
    .wb_sel_o        (wb_sel_o),
    .wb_tga_o        (wb_tga_o),
    .wb_cyc_o        (wb_cyc_o),
    .wb_stb_o        (wb_stb_o),
    .wb_ack_i        (wb_ack_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .insn_o          (insn_o),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .err_o           (err_o)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  // Zero-wait ROM slave: ack in the same cycle as the request.
  assign wb_ack_i = wb_cyc_o & ack_en;
  assign wb_dat_i = rom(wb_adr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model; called just after each falling edge.
  task automatic model_check();
    check_eq("valid", 32'(valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("pc", pc_o, mq[0][63:32]);
      check_eq("insn", insn_o, mq[0][31:0]);
    end
    if (wb_cyc_o) check_eq("adr", wb_adr_o, exp_fa);
    if (mq.size() == DEPTH) check_eq("cyc_full", 32'(wb_cyc_o), 32'd0);
    if (!tmo_test) begin
      check_eq("err", 32'(err_o), 32'd0);
      if (low_prev && mq.size() < DEPTH) check_eq("req_resume", 32'(wb_cyc_o), 32'd1);
    end
    low_prev = !wb_cyc_o && (mq.size() < DEPTH);
  endtask

  // Apply what will happen at the coming rising edge to the model.
  task automatic model_update();
    if (flush_i) begin
      mq.delete();
      exp_fa   = {branch_target_i[31:2], 2'b00};
      low_prev = 1'b0;
    end else begin
      if (ready_i && mq.size() != 0) void'(mq.pop_front());
      if (wb_cyc_o && wb_ack_i) begin
        mq.push_back({exp_fa, rom(exp_fa)});
        exp_fa = exp_fa + 32'd4;
        n_ack++;
      end
    end
  endtask

  task automatic step(input bit rdy, input bit fl, input logic [31:0] tgt, input bit ak);
    ready_i         = rdy;
    flush_i         = fl;
    branch_target_i = tgt;
    ack_en          = ak;
    #1;
    model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic model_reset();
    mq.delete();
    exp_fa   = RESET_PC;
    low_prev = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rp;
    bit  r, a, f;
    logic [31:0] t;
    int  n_bus;

    tmo_test        = 1'b0;
    n_ack           = 0;
    rst_i           = 1'b1;
    ready_i         = 1'b0;
    flush_i         = 1'b0;
    branch_target_i = 32'h0;
    ack_en          = 1'b0;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(wb_stb_o), 32'd0);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_adr", wb_adr_o, RESET_PC);
    check_eq("dat_o", wb_dat_o, 32'h0);
    check_eq("we_o", 32'(wb_we_o), 32'd0);
    check_eq("sel_o", 32'(wb_sel_o), 32'd3);
    check_eq("tga_o", 32'(wb_tga_o), 32'd0);

    // Streaming from reset: one word per cycle.
    rst_i = 1'b0;
    model_check();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      check_eq("s_cyc", 32'(wb_cyc_o), 32'd1);
      check_eq("s_stb", 32'(wb_stb_o), 32'd1);
      check_eq("s_adr", wb_adr_o, RESET_PC + 32'(4 * k));
      if (k >= 1) begin
        check_eq("s_valid", 32'(valid_o), 32'd1);
        check_eq("s_pc", pc_o, RESET_PC + 32'(4 * (k - 1)));
      end
    end

    // Fill with consumer stalled, then one pop allows exactly one fetch.
    step(1'b0, 1'b1, 32'h0000_3000, 1'b1);
    n_ack = 0;
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("fill_acks", 32'(n_ack), 32'd4);
    check_eq("fill_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("fill_pc", pc_o, 32'h0000_3000);
    n_ack = 0;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("pulse_acks", 32'(n_ack), 32'd1);
    check_eq("pulse_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("pulse_pc", pc_o, 32'h0000_3004);

    // Flush coinciding with an ack.
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("pre_fl_cyc", 32'(wb_cyc_o), 32'd1);
    step(1'b1, 1'b1, 32'h0000_2003, 1'b1);
    check_eq("fl_valid", 32'(valid_o), 32'd0);
    check_eq("fl_cyc", 32'(wb_cyc_o), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("fl_bus", 32'(wb_cyc_o), 32'd1);
    check_eq("fl_adr", wb_adr_o, 32'h0000_2000);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("fl_pc", pc_o, 32'h0000_2000);

    // Address wrap at the top of memory.
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wr_adr0", wb_adr_o, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wr_adr1", wb_adr_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wr_adr2", wb_adr_o, 32'h0000_0000);
    check_eq("wr_pc0", pc_o, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("wr_pc1", pc_o, 32'hFFFF_FFFC);

    // Reset asserted in the middle of a bus cycle drops the request at once.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("mr_pre_cyc", 32'(wb_cyc_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("mr_cyc", 32'(wb_cyc_o), 32'd0);
    check_eq("mr_stb", 32'(wb_stb_o), 32'd0);
    check_eq("mr_valid", 32'(valid_o), 32'd0);
    check_eq("mr_adr", wb_adr_o, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    check_eq("mr_hold_cyc", 32'(wb_cyc_o), 32'd0);
    rst_i = 1'b0;
    model_reset();
    model_check();

    // Random mix of ack, consumer readiness and flushes.
    for (int blk = 0; blk < 15; blk++) begin
      rp = $urandom_range(10, 95);
      for (int i = 0; i < 100; i++) begin
        r = ($urandom_range(0, 99) < rp);
        a = ($urandom_range(0, 99) < 70);
        f = ($urandom_range(0, 99) < 3);
        t = $urandom();
        step(r, f, t, a);
      end
    end

    // Slave that never acknowledges.
    tmo_test = 1'b1;
    step(1'b1, 1'b1, 32'h0000_4000, 1'b0);
    n_bus = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (wb_cyc_o) n_bus++;
    end
`ifdef WB_IFETCH_TIMEOUT_EN
    check_eq("tmo_bus_cycles", 32'(n_bus), 32'd16);
    check_eq("tmo_err", 32'(err_o), 32'd1);
    check_eq("tmo_cyc", 32'(wb_cyc_o), 32'd0);
    step(1'b1, 1'b1, 32'h0000_5000, 1'b0);
    check_eq("tmo_err_clr", 32'(err_o), 32'd0);
    check_eq("tmo_fl_cyc", 32'(wb_cyc_o), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("tmo_resume", 32'(wb_cyc_o), 32'd1);
    check_eq("tmo_adr", wb_adr_o, 32'h0000_5000);
`else
    check_eq("wait_bus_cycles", 32'(n_bus), 32'd30);
    check_eq("wait_err", 32'(err_o), 32'd0);
    check_eq("wait_cyc", 32'(wb_cyc_o), 32'd1);
    step(1'b1, 1'b1, 32'h0000_5000, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("wait_adr", wb_adr_o, 32'h0000_5000);
`endif
    tmo_test = 1'b0;
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_wb_ifetch
`default_nettype wire
